// File: rtl/mux_4_rr_sched.sv
// -----------------------------------------------------------------------------
// mux_4_rr_sched
//
// Round-robin scheduler for a 4:1 4-bit channel mux. It arbitrates four request
// lines and drives the mux select from a register, holding each grant for up
// to HOLD accepted beats before rotating to the next requester. The consumer
// of the mux output sees a valid/ack handshake plus a last-beat flag; the data
// itself never passes through this block.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   req    per-channel request, bit i requests channel i
//   ack    downstream accepts the current beat this cycle
//   sel    registered mux select
//   gnt    registered one-hot grant, zero when idle
//   valid  current mux output beat is valid
//   last   current beat is the final beat of this grant
// -----------------------------------------------------------------------------
module mux_4_rr_sched #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       ack,
    output logic [1:0] sel,
    output logic [3:0] gnt,
    output logic       valid,
    output logic       last
);

    localparam int             CW      = (HOLD > 2) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [1:0]      sel_reg,   sel_next;
    logic [1:0]      ptr_reg,   ptr_next;
    logic [3:0]      gnt_reg,   gnt_next;
    logic [CW-1:0]   cnt_reg,   cnt_next;

    // Rotated view of the request vector: cand[k] is the channel examined at
    // scan position k, starting from the round-robin pointer.
    logic [1:0]      cand [4];
    logic [3:0]      hit;
    logic            found;
    logic [1:0]      winner;

    logic            accept;
    logic            rel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_scan
            assign cand[gi] = ptr_reg + 2'(gi);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Lowest scan position with a request wins; iterating from the far end
    // lets the nearest hit overwrite the others.
    always_comb begin
        found  = |hit;
        winner = cand[0];
        for (int i = 3; i >= 0; i--) begin
            if (hit[i]) begin
                winner = cand[i];
            end
        end
    end

    assign valid  = (state_reg == GRANT) & req[sel_reg];
    assign last   = valid & (cnt_reg == CNT_MAX);
    assign accept = valid & ack;
    // Release when the final beat is taken or the owner withdraws its request.
    // Because ptr already points past the owner, the owner is searched last.
    assign rel    = (accept & (cnt_reg == CNT_MAX)) | ~req[sel_reg];

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        gnt_next   = gnt_reg;
        cnt_next   = cnt_reg;

        unique case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    sel_next   = winner;
                    ptr_next   = winner + 2'd1;
                    gnt_next   = 4'b0001 << winner;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    if (found) begin
                        // Back-to-back hand-over, no idle cycle in between.
                        sel_next = winner;
                        ptr_next = winner + 2'd1;
                        gnt_next = 4'b0001 << winner;
                        cnt_next = '0;
                    end else begin
                        // sel keeps its value while idle; only the grant drops.
                        state_next = IDLE;
                        gnt_next   = 4'b0000;
                    end
                end else if (accept) begin
                    cnt_next = cnt_reg + CW'(1);
                end
                // Without an accepted beat everything holds: a stalled
                // grant is never revoked for lack of ack.
            end
            default: begin
                state_next = IDLE;
                gnt_next   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 2'd0;
            ptr_reg   <= 2'd0;
            gnt_reg   <= 4'b0000;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            gnt_reg   <= gnt_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign sel = sel_reg;
    assign gnt = gnt_reg;

endmodule

// File: tb/tb_mux_4_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_mux_4_rr_sched
//
// Directed bench for mux_4_rr_sched. One instance uses the default HOLD=4;
// a second instance with HOLD=1 shares the stimulus and is checked during the
// full-rotation step, where every beat must be a last beat.
// Inputs change 2 time units after a rising edge; outputs are checked 1 unit
// later, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_mux_4_rr_sched;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       ack;

    logic [1:0] sel;
    logic [3:0] gnt;
    logic       valid;
    logic       last;

    logic [1:0] sel1;
    logic [3:0] gnt1;
    logic       valid1;
    logic       last1;

    int total = 0;
    int bad   = 0;

    mux_4_rr_sched #(.HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ack   (ack),
        .sel   (sel),
        .gnt   (gnt),
        .valid (valid),
        .last  (last)
    );

    mux_4_rr_sched #(.HOLD(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ack   (ack),
        .sel   (sel1),
        .gnt   (gnt1),
        .valid (valid1),
        .last  (last1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: inputs may change right after this returns.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        ack = 1'b0;

        // Reset state
        cyc();
        chk("rst_sel",   4'(sel),   4'd0);
        chk("rst_gnt",   gnt,       4'b0000);
        chk("rst_valid", 4'(valid), 4'd0);
        chk("rst_last",  4'(last),  4'd0);
        rst = 1'b0;

        // 1. Full rotation, no backpressure
        req = 4'b1111;
        ack = 1'b1;
        #1;
        chk("t1_idle_valid",  4'(valid),  4'd0);
        chk("t1_idle_valid1", 4'(valid1), 4'd0);
        cyc();
        for (int b = 0; b < 17; b++) begin
            chk($sformatf("t1_sel_b%0d", b),   4'(sel),   4'((b / 4) % 4));
            chk($sformatf("t1_gnt_b%0d", b),   gnt,       4'(4'b0001 << ((b / 4) % 4)));
            chk($sformatf("t1_valid_b%0d", b), 4'(valid), 4'd1);
            chk($sformatf("t1_last_b%0d", b),  4'(last),  4'((b % 4) == 3));
            chk($sformatf("t1_h1_sel_b%0d", b),  4'(sel1),  4'(b % 4));
            chk($sformatf("t1_h1_last_b%0d", b), 4'(last1), 4'd1);
            cyc();
        end

        // 2. Single requester: channel 2 re-granted every 4 beats
        req = 4'b0100;
        #1;
        chk("t2_drop_valid", 4'(valid), 4'd0);
        cyc();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2_sel_k%0d", k),   4'(sel),   4'd2);
            chk($sformatf("t2_gnt_k%0d", k),   gnt,       4'b0100);
            chk($sformatf("t2_valid_k%0d", k), 4'(valid), 4'd1);
            chk($sformatf("t2_last_k%0d", k),  4'(last),  4'((k % 4) == 3));
            cyc();
        end

        // 3. Backpressure on channel 1 with one beat already taken
        req = 4'b0010;
        #1;
        chk("t3_drop_valid", 4'(valid), 4'd0);
        cyc();
        chk("t3_sel",   4'(sel),   4'd1);
        chk("t3_valid", 4'(valid), 4'd1);
        cyc();
        ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t3_stall_valid_k%0d", k), 4'(valid), 4'd1);
            chk($sformatf("t3_stall_sel_k%0d", k),   4'(sel),   4'd1);
            chk($sformatf("t3_stall_gnt_k%0d", k),   gnt,       4'b0010);
            chk($sformatf("t3_stall_last_k%0d", k),  4'(last),  4'd0);
            cyc();
        end
        ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t3_resume_sel_k%0d", k),  4'(sel),  4'd1);
            chk($sformatf("t3_resume_last_k%0d", k), 4'(last), 4'(k == 2));
            cyc();
        end

        // 4. Owner (channel 1) drops its request after 2 beats
        req = 4'b1010;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t4_own_sel_k%0d", k),   4'(sel),   4'd1);
            chk($sformatf("t4_own_valid_k%0d", k), 4'(valid), 4'd1);
            chk($sformatf("t4_own_last_k%0d", k),  4'(last),  4'd0);
            cyc();
        end
        req = 4'b1000;
        #1;
        chk("t4_drop_valid", 4'(valid), 4'd0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_new_sel_k%0d", k),   4'(sel),   4'd3);
            chk($sformatf("t4_new_gnt_k%0d", k),   gnt,       4'b1000);
            chk($sformatf("t4_new_valid_k%0d", k), 4'(valid), 4'd1);
            chk($sformatf("t4_new_last_k%0d", k),  4'(last),  4'(k == 3));
            cyc();
        end

        // 5. All requests drop during a channel-3 grant
        req = 4'b0000;
        #1;
        chk("t5_drop_valid", 4'(valid), 4'd0);
        cyc();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t5_idle_gnt_k%0d", k),   gnt,       4'b0000);
            chk($sformatf("t5_idle_valid_k%0d", k), 4'(valid), 4'd0);
            chk($sformatf("t5_idle_sel_k%0d", k),   4'(sel),   4'd3);
            chk($sformatf("t5_idle_last_k%0d", k),  4'(last),  4'd0);
            cyc();
        end
        req = 4'b0001;
        #1;
        chk("t5_req_valid", 4'(valid), 4'd0);
        chk("t5_req_gnt",   gnt,       4'b0000);
        cyc();
        chk("t5_gnt0_sel",   4'(sel),   4'd0);
        chk("t5_gnt0_gnt",   gnt,       4'b0001);
        chk("t5_gnt0_valid", 4'(valid), 4'd1);

        // 6. Asynchronous reset in the middle of a channel-2 grant
        req = 4'b0100;
        #1;
        chk("t6_drop_valid", 4'(valid), 4'd0);
        cyc();
        chk("t6_pre_sel", 4'(sel), 4'd2);
        chk("t6_pre_gnt", gnt,     4'b0100);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt",   gnt,       4'b0000);
        chk("t6_rst_valid", 4'(valid), 4'd0);
        chk("t6_rst_sel",   4'(sel),   4'd0);
        chk("t6_rst_last",  4'(last),  4'd0);
        req = 4'b1111;
        cyc();
        chk("t6_hold_gnt", gnt, 4'b0000);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_after_valid", 4'(valid), 4'd0);
        cyc();
        chk("t6_first_sel",   4'(sel),   4'd0);
        chk("t6_first_gnt",   gnt,       4'b0001);
        chk("t6_first_valid", 4'(valid), 4'd1);
        chk("t6_first_gnt1",  gnt1,      4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
